fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 43 ++++
 rtl/fetch_unit_if_id_reg.sv | 47 ++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and defaults for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_PC_INCR    = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3,
        ST_HOLD = 3'd4
    } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : PC-register, instruction-memory and IF/ID handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] i_PC;
    logic                  o_Load;
    logic [DATA_WIDTH-1:0] o_NextPC;
    logic                  i_Redirect;
    logic [DATA_WIDTH-1:0] i_RedirectPC;
    logic                  o_ImemReq;
    logic [DATA_WIDTH-1:0] o_ImemAddr;
    logic                  i_ImemGnt;
    logic                  i_ImemRValid;
    logic [DATA_WIDTH-1:0] i_ImemRData;
    logic                  o_IfValid;
    logic [DATA_WIDTH-1:0] o_IfInstr;
    logic [DATA_WIDTH-1:0] o_IfPC;
    logic                  i_IdReady;

    // The fetch unit is the master; pc register, memory and decode form the slave side.
    modport master (
        input  i_PC, i_Redirect, i_RedirectPC, i_ImemGnt, i_ImemRValid,
               i_ImemRData, i_IdReady,
        output o_Load, o_NextPC, o_ImemReq, o_ImemAddr, o_IfValid,
               o_IfInstr, o_IfPC
    );

    modport slave (
        output i_PC, i_Redirect, i_RedirectPC, i_ImemGnt, i_ImemRValid,
               i_ImemRData, i_IdReady,
        input  o_Load, o_NextPC, o_ImemReq, o_ImemAddr, o_IfValid,
               o_IfInstr, o_IfPC
    );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : Single-entry IF/ID slot holding an instruction and its PC.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire                   i_load,
    input  wire                   i_clear,
    input  wire  [DATA_WIDTH-1:0] i_data,
    input  wire  [DATA_WIDTH-1:0] i_pc,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [DATA_WIDTH-1:0] o_pc
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_pc;

    // Clearing only drops the valid flag; payload stays put until the next fill.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_data;
            r_pc    <= i_pc;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch with redirect handling.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PC_INCR    = DEFAULT_PC_INCR
) (
    input  wire          clk,
    input  wire          reset,
    fetch_unit_if.master bus
);

    localparam logic [DATA_WIDTH-1:0] c_PC_INCR = DATA_WIDTH'(PC_INCR);

    fetch_state_t          r_state;
    logic                  r_imem_req;
    logic [DATA_WIDTH-1:0] r_req_pc;

    logic                  w_accept;
    logic                  w_fill;
    logic                  w_slot_clear;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_slot_valid;
    logic [DATA_WIDTH-1:0] w_slot_instr;
    logic [DATA_WIDTH-1:0] w_slot_pc;

    assign w_accept     = (r_state == ST_HOLD) && bus.i_IdReady;
    assign w_fill       = (r_state == ST_WAIT) && bus.i_ImemRValid && !bus.i_Redirect;
    assign w_slot_clear = (r_state == ST_HOLD) && (bus.i_IdReady || bus.i_Redirect);

    // Redirect wins over sequential advance; nothing loads while reset is held.
    always_comb begin
        w_load    = 1'b0;
        w_next_pc = '0;
        if (reset) begin
            if (bus.i_Redirect) begin
                w_load    = 1'b1;
                w_next_pc = bus.i_RedirectPC;
            end else if (w_accept) begin
                w_load    = 1'b1;
                w_next_pc = bus.i_PC + c_PC_INCR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_imem_req <= 1'b0;
            r_req_pc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_REQ;
                    r_imem_req <= 1'b1;
                end
                ST_REQ: begin
                    if (bus.i_ImemGnt) begin
                        r_req_pc   <= bus.i_PC;
                        r_imem_req <= 1'b0;
                        r_state    <= bus.i_Redirect ? ST_DROP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_ImemRValid) begin
                        r_state    <= bus.i_Redirect ? ST_REQ : ST_HOLD;
                        r_imem_req <= bus.i_Redirect;
                    end else if (bus.i_Redirect) begin
                        r_state <= ST_DROP;
                    end
                end
                // The in-flight response belongs to the abandoned path.
                ST_DROP: begin
                    if (bus.i_ImemRValid) begin
                        r_state    <= ST_REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.i_IdReady || bus.i_Redirect) begin
                        r_state    <= ST_REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_fill),
        .i_clear (w_slot_clear),
        .i_data  (bus.i_ImemRData),
        .i_pc    (r_req_pc),
        .o_valid (w_slot_valid),
        .o_instr (w_slot_instr),
        .o_pc    (w_slot_pc)
    );

    assign bus.o_Load     = w_load;
    assign bus.o_NextPC   = w_next_pc;
    assign bus.o_ImemReq  = r_imem_req;
    assign bus.o_ImemAddr = r_imem_req ? bus.i_PC : '0;
    assign bus.o_IfValid  = w_slot_valid;
    assign bus.o_IfInstr  = w_slot_instr;
    assign bus.o_IfPC     = w_slot_pc;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed vector table plus randomized run against a flag model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.DATA_WIDTH(32)) bus ();

    fetch_unit #(
        .DATA_WIDTH (32),
        .PC_INCR    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_load;
        logic [31:0] e_npc;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        care;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_load, input logic [31:0] e_npc, input logic e_v,
                                input logic [31:0] e_instr, input logic [31:0] e_ipc,
                                input logic care);
        vec_t v;
        v.rst = rst;     v.redir = redir;   v.rpc = rpc;     v.gnt = gnt;
        v.rv = rv;       v.rdata = rdata;   v.rdy = rdy;     v.e_req = e_req;
        v.e_addr = e_addr; v.e_load = e_load; v.e_npc = e_npc; v.e_v = e_v;
        v.e_instr = e_instr; v.e_ipc = e_ipc; v.care = care;
        return v;
    endfunction

    task automatic chk(input string tag, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", tag, nm, act, exp);
        end
    endtask

    // One clock: drive, check mid-cycle, clock, then the pc register responds.
    task automatic apply(input vec_t v, input string tag);
        logic        ld;
        logic [31:0] np;
        reset            = v.rst;
        bus.i_Redirect   = v.redir;
        bus.i_RedirectPC = v.rpc;
        bus.i_ImemGnt    = v.gnt;
        bus.i_ImemRValid = v.rv;
        bus.i_ImemRData  = v.rdata;
        bus.i_IdReady    = v.rdy;
        @(negedge clk);
        chk(tag, "ImemReq", {31'd0, bus.o_ImemReq}, {31'd0, v.e_req});
        if (v.e_req || !v.rst) chk(tag, "ImemAddr", bus.o_ImemAddr, v.e_addr);
        chk(tag, "Load", {31'd0, bus.o_Load}, {31'd0, v.e_load});
        if (v.e_load || !v.rst) chk(tag, "NextPC", bus.o_NextPC, v.e_npc);
        chk(tag, "IfValid", {31'd0, bus.o_IfValid}, {31'd0, v.e_v});
        if (v.care) begin
            chk(tag, "IfInstr", bus.o_IfInstr, v.e_instr);
            chk(tag, "IfPC", bus.o_IfPC, v.e_ipc);
        end
        ld = bus.o_Load;
        np = bus.o_NextPC;
        @(posedge clk);
        #1;
        if (!v.rst) bus.i_PC = 32'h0;
        else if (ld) bus.i_PC = np;
    endtask

    // Reference model: request/outstanding/slot flags updated per spec rules.
    logic        m_started, m_req, m_out, m_stale, m_sv, m_zero;
    logic [31:0] m_si, m_sp, m_rpc;

    initial begin
        vec_t        v;
        logic [31:0] cur_pc;
        logic        acc;

        bus.i_PC = 32'h0; bus.i_Redirect = 1'b0; bus.i_RedirectPC = 32'h0;
        bus.i_ImemGnt = 1'b0; bus.i_ImemRValid = 1'b0; bus.i_ImemRData = 32'h0;
        bus.i_IdReady = 1'b0;
        @(posedge clk);
        #1;

        // Reset, first fetch, stall in HOLD, redirects in HOLD and REQ, PC wrap
        tbl.push_back(mk(0,0,0,0,0,0,0,            0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,            0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,1,0,0,0,            1,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,1,32'hE3A00001,0, 0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,1,            0,0,1,4,1,32'hE3A00001,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,            1,4,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,0,0,            1,4,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,            0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,32'h11111111,0, 0,0,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1,0,0,0,0,0,0,        0,0,0,0,1,32'h11111111,4,1));
        tbl.push_back(mk(1,1,32'h200,0,0,0,1,      0,0,1,32'h200,1,32'h11111111,4,1));
        tbl.push_back(mk(1,0,0,1,0,0,0,            1,32'h200,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,32'h22222222,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,32'hFFFFFFFC,0,0,0,0, 0,0,1,32'hFFFFFFFC,1,32'h22222222,32'h200,1));
        tbl.push_back(mk(1,0,0,1,0,0,0,            1,32'hFFFFFFFC,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,32'h33333333,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,1,            0,0,1,32'h0,1,32'h33333333,32'hFFFFFFFC,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,            1,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,32'h40,0,0,0,0,       1,0,1,32'h40,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,            1,32'h40,0,0,0,0,0,0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Redirect while waiting: stale response dropped, refetch from target
        apply(mk(1,0,0,1,0,0,0,            1,32'h40,0,0,0,0,0,0),                "drop_gnt");
        apply(mk(1,1,32'h100,0,0,0,0,      0,0,1,32'h100,0,0,0,0),               "drop_redir");
        apply(mk(1,0,0,0,1,32'hDEADBEEF,0, 0,0,0,0,0,0,0,0),                     "drop_stale");
        apply(mk(1,0,0,0,0,0,0,            1,32'h100,0,0,0,0,0,0),               "drop_req");
        apply(mk(1,0,0,1,0,0,0,            1,32'h100,0,0,0,0,0,0),               "drop_gnt2");
        apply(mk(1,0,0,0,0,0,0,            0,0,0,0,0,0,0,0),                     "drop_wait");
        apply(mk(1,0,0,0,1,32'h44444444,0, 0,0,0,0,0,0,0,0),                     "drop_fill");
        apply(mk(1,0,0,0,0,0,0,            0,0,0,0,1,32'h44444444,32'h100,1),    "drop_hold");
        apply(mk(1,0,0,0,0,0,1,            0,0,1,32'h104,1,32'h44444444,32'h100,1), "drop_acc");

        // Reset while waiting: late response ignored, restart from pc reset value
        apply(mk(1,0,0,1,0,0,0,            1,32'h104,0,0,0,0,0,0),               "rst_gnt");
        apply(mk(0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0),                     "rst_assert");
        apply(mk(1,0,0,0,1,32'h55555555,0, 0,0,0,0,0,0,0,1),                     "rst_late");
        apply(mk(1,0,0,0,0,0,0,            1,0,0,0,0,0,0,1),                     "rst_restart");

        m_started = 1'b1; m_req = 1'b1; m_out = 1'b0; m_stale = 1'b0;
        m_sv = 1'b0; m_zero = 1'b1; m_si = 32'h0; m_sp = 32'h0; m_rpc = 32'h0;

        for (int c = 0; c < 600; c++) begin
            cur_pc  = bus.i_PC;
            v.rst   = ($urandom_range(0, 79) != 0);
            v.redir = ($urandom_range(0, 9) == 0);
            v.rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
            v.gnt   = m_req && ($urandom_range(0, 2) != 0);
            v.rv    = m_out && ($urandom_range(0, 2) != 0);
            v.rdata = $urandom();
            v.rdy   = ($urandom_range(0, 2) != 0);
            acc     = m_sv && v.rdy;

            v.e_req   = m_req;
            v.e_addr  = m_req ? cur_pc : 32'h0;
            v.e_load  = v.rst && (v.redir || acc);
            v.e_npc   = !v.rst ? 32'h0 : v.redir ? v.rpc : acc ? cur_pc + 32'd4 : 32'h0;
            v.e_v     = m_sv;
            v.e_instr = m_si;
            v.e_ipc   = m_sp;
            v.care    = m_sv || m_zero;
            apply(v, $sformatf("rnd%0d", c));

            if (!v.rst) begin
                m_started = 1'b0; m_req = 1'b0; m_out = 1'b0; m_stale = 1'b0;
                m_sv = 1'b0; m_zero = 1'b1; m_si = 32'h0; m_sp = 32'h0;
            end else if (!m_started) begin
                m_started = 1'b1;
                m_req     = 1'b1;
            end else if (m_req) begin
                if (v.gnt) begin
                    m_req = 1'b0; m_out = 1'b1; m_stale = v.redir; m_rpc = cur_pc;
                end
            end else if (m_out) begin
                if (v.rv) begin
                    m_out = 1'b0;
                    if (m_stale || v.redir) m_req = 1'b1;
                    else begin
                        m_sv = 1'b1; m_si = v.rdata; m_sp = m_rpc; m_zero = 1'b0;
                    end
                end else if (v.redir) begin
                    m_stale = 1'b1;
                end
            end else if (m_sv && (v.rdy || v.redir)) begin
                m_sv  = 1'b0;
                m_req = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
